// File: rtl/qam16_slicer_ber.sv
// 16-QAM receive slicer: picks one sample per symbol, demaps it and counts symbol errors
// over 2^WIN_LOG2-symbol windows. Define SLICER_SQ_ERR_EN to add the squared-error sum.
module qam16_slicer_ber #(
   parameter int unsigned REF_DELAY = 8,
   parameter int unsigned WIN_LOG2  = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sam_clk_en,
   input  logic               sym_clk_en,
   input  logic [1:0]         phase_sel,
   input  logic signed [17:0] in_i,
   input  logic signed [17:0] in_q,
   input  logic [17:0]        thresh,
   input  logic [3:0]         ref_sym,
   output logic [3:0]         dec_sym,
   output logic               dec_valid,
   output logic [WIN_LOG2:0]  err_count,
   output logic               window_done,
   output logic               busy
`ifdef SLICER_SQ_ERR_EN
   ,
   output logic [47:0]        sq_err_sum
`endif
);

   typedef enum logic [1:0] {StFill, StMeasure, StDone} state_e;

   localparam logic [WIN_LOG2:0] WinLen = {1'b1, {WIN_LOG2{1'b0}}};

   logic [1:0]         ph_q, phsel_q, ph_cur, phsel_eff;
   logic               sym_start, take;
   logic signed [17:0] cap_i_q, cap_q_q;
   logic               cap_vld_q;
   logic [3:0]         ref_dl [REF_DELAY];
   logic [3:0]         ref_tap;
   state_e             state_q;
   logic [4:0]         fill_q;
   logic [WIN_LOG2:0]  sym_cnt_q, err_acc_q, sym_nxt, err_nxt;
   logic               err_hit;

   function automatic logic [1:0] slice(input logic signed [17:0] x, input logic [17:0] t);
      logic signed [19:0] xs, ts;
      xs = {{2{x[17]}}, x};
      ts = {2'b00, t};
      if (xs >= ts)          slice = 2'b10;
      else if (xs >= 20'sd0) slice = 2'b11;
      else if (xs >= -ts)    slice = 2'b01;
      else                   slice = 2'b00;
   endfunction

   assign sym_start = sam_clk_en & sym_clk_en;
   assign ph_cur    = sym_start ? 2'd0 : ph_q + 2'd1;
   // phase_sel is resampled only at a symbol boundary so a change never splits a symbol
   assign phsel_eff = sym_start ? phase_sel : phsel_q;
   assign take      = sam_clk_en & (ph_cur == phsel_eff);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph_q      <= '0;
         phsel_q   <= '0;
         cap_i_q   <= '0;
         cap_q_q   <= '0;
         cap_vld_q <= 1'b0;
         dec_sym   <= '0;
         dec_valid <= 1'b0;
      end else begin
         cap_vld_q <= take;
         dec_valid <= cap_vld_q;
         if (sam_clk_en) ph_q <= ph_cur;
         if (sym_start) phsel_q <= phase_sel;
         if (take) begin
            cap_i_q <= in_i;
            cap_q_q <= in_q;
         end
         if (cap_vld_q) dec_sym <= {slice(cap_i_q, thresh), slice(cap_q_q, thresh)};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < REF_DELAY; k++) ref_dl[k] <= '0;
      end else if (sym_clk_en) begin
         ref_dl[0] <= ref_sym;
         for (int unsigned k = 1; k < REF_DELAY; k++) ref_dl[k] <= ref_dl[k-1];
      end
   end

   assign ref_tap = ref_dl[REF_DELAY-1];
   assign err_hit = dec_valid && (dec_sym != ref_tap);
   assign sym_nxt = sym_cnt_q + {{WIN_LOG2{1'b0}}, 1'b1};
   assign err_nxt = err_acc_q + {{WIN_LOG2{1'b0}}, err_hit};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StFill;
         fill_q      <= '0;
         sym_cnt_q   <= '0;
         err_acc_q   <= '0;
         err_count   <= '0;
         window_done <= 1'b0;
         busy        <= 1'b0;
      end else begin
         window_done <= 1'b0;
         case (state_q)
            StFill: begin
               if (dec_valid) begin
                  if (fill_q == 5'(REF_DELAY - 1)) begin
                     state_q <= StMeasure;
                     busy    <= 1'b1;
                  end else begin
                     fill_q <= fill_q + 5'd1;
                  end
               end
            end
            StMeasure: begin
               if (dec_valid) begin
                  sym_cnt_q <= sym_nxt;
                  err_acc_q <= err_nxt;
                  if (sym_nxt == WinLen) begin
                     err_count   <= err_nxt;
                     window_done <= 1'b1;
                     state_q     <= StDone;
                  end
               end
            end
            StDone: begin
               // a stray decision here opens the next window rather than being lost
               sym_cnt_q <= {{WIN_LOG2{1'b0}}, dec_valid};
               err_acc_q <= {{WIN_LOG2{1'b0}}, err_hit};
               state_q   <= StMeasure;
            end
            default: state_q <= StFill;
         endcase
      end
   end

`ifdef SLICER_SQ_ERR_EN
   function automatic logic signed [17:0] lvl_err(input logic signed [17:0] x,
                                                  input logic [17:0] t);
      logic signed [20:0] xs, half, three_half, xhat, diff;
      xs         = {{3{x[17]}}, x};
      half       = {4'b0000, t[17:1]};
      three_half = ({3'b000, t} + {2'b00, t, 1'b0}) >> 1;
      case (slice(x, t))
         2'b10:   xhat = three_half;
         2'b11:   xhat = half;
         2'b01:   xhat = -half;
         default: xhat = -three_half;
      endcase
      diff = xs - xhat;
      if (diff > 21'sd131071)       lvl_err = 18'sd131071;
      else if (diff < -21'sd131072) lvl_err = 18'sh20000;
      else                          lvl_err = diff[17:0];
   endfunction

   function automatic logic [47:0] sat_add(input logic [47:0] acc, input logic [35:0] a,
                                           input logic [35:0] b);
      logic [48:0] s;
      s = {1'b0, acc} + {13'd0, a} + {13'd0, b};
      sat_add = s[48] ? '1 : s[47:0];
   endfunction

   logic signed [17:0] d_i_q, d_q_q;
   logic signed [35:0] prod_i, prod_q;
   logic [47:0]        sq_acc_q, sq_nxt;

   assign prod_i = d_i_q * d_i_q;
   assign prod_q = d_q_q * d_q_q;
   assign sq_nxt = sat_add(sq_acc_q, prod_i, prod_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_i_q      <= '0;
         d_q_q      <= '0;
         sq_acc_q   <= '0;
         sq_err_sum <= '0;
      end else begin
         if (cap_vld_q) begin
            d_i_q <= lvl_err(cap_i_q, thresh);
            d_q_q <= lvl_err(cap_q_q, thresh);
         end
         case (state_q)
            StMeasure: begin
               if (dec_valid) begin
                  sq_acc_q <= sq_nxt;
                  if (sym_nxt == WinLen) sq_err_sum <= sq_nxt;
               end
            end
            StDone:  sq_acc_q <= dec_valid ? sat_add('0, prod_i, prod_q) : '0;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: doc/qam16_slicer_ber.md
Name: qam16_slicer_ber

Overview:
- Receive-side counterpart of the 16-QAM transmit chain (LFSR -> mapper -> upsampler_4).
- Takes I/Q samples at sample rate and downsamples by 4 at a selectable sample phase.
- Slices each symbol to the nearest 16-QAM level and demaps it back to a 4-bit symbol.
- Compares the result against the delayed LFSR reference symbol and reports symbol-error counts over fixed measurement windows for BER evaluation on the board.

Parameters:
- REF_DELAY, 8: symbols of delay applied to ref_sym before comparison. Range 1..31.
- WIN_LOG2, 20: measurement window length is 2^WIN_LOG2 symbols.

Ports:
- clk  in  1  system clock (sys_clk)
- reset  in  1  asynchronous, active-high reset
- sam_clk_en  in  1  one-cycle sample-rate enable
- sym_clk_en  in  1  one-cycle symbol-rate enable; coincides with a sam_clk_en pulse
- phase_sel  in  2  which of the 4 samples per symbol is taken (0..3)
- in_i  in  18  in-phase sample, signed 1s17
- in_q  in  18  quadrature sample, signed 1s17
- thresh  in  18  decision threshold 2a, unsigned positive, 1s17 format
- ref_sym  in  4  transmitted symbol from the LFSR, valid at sym_clk_en
- dec_sym  out  4  sliced symbol
- dec_valid  out  1  one-cycle pulse when dec_sym updates
- err_count  out  WIN_LOG2+1  errors counted in the last completed window
- window_done  out  1  one-cycle pulse when err_count updates
- busy  out  1  high while a window is being measured

Behaviour:
- Reset: all outputs are 0; all counters, delay line and FSM are cleared; FSM state is FILL.
- Phase counter (2 bits):
  - Set to 0 on a cycle where sym_clk_en=1 and sam_clk_en=1.
  - Otherwise increments on each sam_clk_en.
  - The sample is captured on the sam_clk_en cycle where the counter value equals phase_sel.
- Slicing (per axis, combinational on the captured register, registered into dec_sym):
  - x >= thresh -> 2'b10 (+3a)
  - 0 <= x < thresh -> 2'b11 (+a)
  - -thresh <= x < 0 -> 2'b01 (-a)
  - x < -thresh -> 2'b00 (-3a)
  - Ties go to the upper decision region.
  - dec_sym = {I bits, Q bits}, matching the mapper's bit order.
- Latency: dec_sym and dec_valid are asserted 2 clk after the capturing sam_clk_en. dec_valid is 1 cycle wide.
- Reference delay line: REF_DELAY-deep shift register of 4-bit entries, advanced on sym_clk_en. Comparison uses the output tap against dec_sym at dec_valid.
- FSM:
  - FILL: counts REF_DELAY dec_valid pulses, then goes to MEASURE. busy=0.
  - MEASURE: busy=1. On each dec_valid, sym_cnt++ and err_acc++ if dec_sym != delayed ref.
    - When sym_cnt reaches 2^WIN_LOG2, latch err_count = err_acc (including the final symbol), pulse window_done, and go to DONE.
  - DONE: exactly 1 cycle. Clears err_acc and sym_cnt, then goes to MEASURE (windows run back-to-back).
  - A dec_valid arriving in DONE is not possible given the enable spacing. If it does occur, it is counted in the next window.
- Width rules:
  - err_acc is WIN_LOG2+1 bits so an all-error window (2^WIN_LOG2) does not wrap.
  - sym_cnt is WIN_LOG2+1 bits.
- phase_sel change mid-window: takes effect at the next symbol boundary. The window is not restarted.
- reset mid-window: the partial window is discarded, err_count returns to 0, and the FSM restarts in FILL.

Optional Feature:
- Macro: SLICER_SQ_ERR_EN.
- Defined:
  - Adds output sq_err_sum (48 bits), latched at window_done.
  - Holds the window sum of (x - xhat)^2 over both axes.
  - xhat is the ideal level: ±thresh/2 or ±3·thresh/2.
  - Each square is the 36-bit full product; the accumulator saturates at all-ones.
  - Adds 1 cycle of pipeline before the compare.
  - dec_valid latency and window_done timing are unchanged (accumulation runs in parallel).
- Not defined: the port and all logic are absent.

Test Plan:
- Noiseless loopback:
  - Stimulus: transmit-chain I/Q into in_i/in_q, thresh=2a, phase_sel=0, REF_DELAY set to the chain delay, WIN_LOG2=8.
  - Response: dec_sym equals ref_sym delayed; err_count=0 at every window_done; first window_done after 8+256 symbols.
- Level boundaries:
  - Stimulus: in_i = thresh, thresh-1, 0, -1, -thresh, -thresh-1 (in_q=0).
  - Response: I bits 10, 11, 11, 01, 01, 00.
- All-error window:
  - Stimulus: ref_sym forced to the complement of the transmitted symbol, WIN_LOG2=4.
  - Response: err_count=16, no wrap.
- Phase select:
  - Stimulus: upsampler output (one nonzero sample per symbol) with phase_sel=1.
  - Response: all decisions from zero input are 2'b11/2'b11, producing errors. With phase_sel=0: 0 errors.
- Reset mid-window:
  - Stimulus: assert reset at symbol 100 of 256, release.
  - Response: outputs 0 immediately (asynchronous); next window_done after REF_DELAY+256 symbols.
- SLICER_SQ_ERR_EN defined:
  - Stimulus: constant in_i = a+10, in_q = a, WIN_LOG2=4.
  - Response: sq_err_sum = 1600.
